// File: rtl/axi_wr_arbiter_pkg.sv
// rtl/axi_wr_arbiter_pkg.sv - shared FSM encoding and write response codes
package axi_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_wr_arbiter_rr_arb2.sv
// rtl/axi_wr_arbiter_rr_arb2.sv - two-way round-robin arbiter with one-hot grant
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On contention the requester that was not served last wins.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - two-requester AXI write arbiter onto one shared slave
module axi_wr_arbiter
    import axi_wr_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    // requester 0
    input  logic [ADDR_W-1:0] m0_axi_awaddr,
    input  logic              m0_axi_awvalid,
    output logic              m0_axi_awready,
    input  logic [DATA_W-1:0] m0_axi_wdata,
    input  logic              m0_axi_wvalid,
    input  logic              m0_axi_wlast,
    output logic              m0_axi_wready,
    output logic [1:0]        m0_axi_bresp,
    output logic              m0_axi_bvalid,
    input  logic              m0_axi_bready,
    // requester 1
    input  logic [ADDR_W-1:0] m1_axi_awaddr,
    input  logic              m1_axi_awvalid,
    output logic              m1_axi_awready,
    input  logic [DATA_W-1:0] m1_axi_wdata,
    input  logic              m1_axi_wvalid,
    input  logic              m1_axi_wlast,
    output logic              m1_axi_wready,
    output logic [1:0]        m1_axi_bresp,
    output logic              m1_axi_bvalid,
    input  logic              m1_axi_bready,
    // shared slave
    output logic [ADDR_W-1:0] s_axi_awaddr,
    output logic              s_axi_awvalid,
    input  logic              s_axi_awready,
    output logic [DATA_W-1:0] s_axi_wdata,
    output logic              s_axi_wvalid,
    output logic              s_axi_wlast,
    input  logic              s_axi_wready,
    input  logic [1:0]        s_axi_bresp,
    input  logic              s_axi_bvalid,
    output logic              s_axi_bready
);

    arb_state_e  state;
    arb_state_e  state_nxt;
    logic        grant;       // 0 = requester 0, 1 = requester 1
    logic        last_served;
    logic [15:0] beat_cnt;    // beats of the current burst, debug only
    logic [1:0]  arb_gnt;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;

    rr_arb2 u_rr_arb2 (
        .req  ({m1_axi_awvalid, m0_axi_awvalid}),
        .last (last_served),
        .gnt  (arb_gnt)
    );

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign b_hs  = s_axi_bvalid && s_axi_bready;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pointer resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            grant       <= 1'b0;
            last_served <= 1'b1;
            beat_cnt    <= '0;
        end else begin
            if (state == ST_IDLE && (m0_axi_awvalid || m1_axi_awvalid)) begin
                grant    <= arb_gnt[1];
                beat_cnt <= '0;
            end
            if (state == ST_DATA && w_hs) begin
                beat_cnt <= beat_cnt + 16'd1;
            end
            if (state == ST_RESP && b_hs) begin
                last_served <= grant;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (m0_axi_awvalid || m1_axi_awvalid) state_nxt = ST_ADDR;
            ST_ADDR: if (aw_hs) state_nxt = ST_DATA;
            ST_DATA: if (w_hs && s_axi_wlast) state_nxt = ST_RESP;
            ST_RESP: if (b_hs) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Each channel is only connected in its own state; everything else is
    // held at zero so the idle requester and the slave see quiet buses.
    always_comb begin
        m0_axi_awready = 1'b0;
        m1_axi_awready = 1'b0;
        m0_axi_wready  = 1'b0;
        m1_axi_wready  = 1'b0;
        m0_axi_bresp   = RESP_OKAY;
        m1_axi_bresp   = RESP_OKAY;
        m0_axi_bvalid  = 1'b0;
        m1_axi_bvalid  = 1'b0;
        s_axi_awaddr   = '0;
        s_axi_awvalid  = 1'b0;
        s_axi_wdata    = '0;
        s_axi_wvalid   = 1'b0;
        s_axi_wlast    = 1'b0;
        s_axi_bready   = 1'b0;
        case (state)
            ST_ADDR: begin
                s_axi_awaddr   = grant ? m1_axi_awaddr : m0_axi_awaddr;
                s_axi_awvalid  = grant ? m1_axi_awvalid : m0_axi_awvalid;
                m0_axi_awready = !grant && s_axi_awready;
                m1_axi_awready = grant && s_axi_awready;
            end
            ST_DATA: begin
                s_axi_wdata   = grant ? m1_axi_wdata : m0_axi_wdata;
                s_axi_wvalid  = grant ? m1_axi_wvalid : m0_axi_wvalid;
                s_axi_wlast   = grant ? m1_axi_wlast : m0_axi_wlast;
                m0_axi_wready = !grant && s_axi_wready;
                m1_axi_wready = grant && s_axi_wready;
            end
            ST_RESP: begin
                s_axi_bready = grant ? m1_axi_bready : m0_axi_bready;
                if (grant) begin
                    m1_axi_bresp  = s_axi_bresp;
                    m1_axi_bvalid = s_axi_bvalid;
                end else begin
                    m0_axi_bresp  = s_axi_bresp;
                    m0_axi_bvalid = s_axi_bvalid;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb/tb_axi_wr_arbiter.sv - scoreboard bench for axi_wr_arbiter
module tb_axi_wr_arbiter;
    import axi_wr_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        axi_aresetn;
    logic [15:0] m_awaddr [2];
    logic [7:0]  m_wdata  [2];
    logic [1:0]  m_awvalid, m_wvalid, m_wlast, m_bready;
    wire  [1:0]  m_awready, m_wready, m_bvalid;
    wire  [1:0]  m0_bresp, m1_bresp;
    logic        s_awready, s_wready, s_bvalid;
    logic [1:0]  s_bresp;
    wire  [15:0] s_awaddr;
    wire  [7:0]  s_wdata;
    wire         s_awvalid, s_wvalid, s_wlast, s_bready;

    axi_wr_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .axi_aclk       (clk),
        .axi_aresetn    (axi_aresetn),
        .m0_axi_awaddr  (m_awaddr[0]),
        .m0_axi_awvalid (m_awvalid[0]),
        .m0_axi_awready (m_awready[0]),
        .m0_axi_wdata   (m_wdata[0]),
        .m0_axi_wvalid  (m_wvalid[0]),
        .m0_axi_wlast   (m_wlast[0]),
        .m0_axi_wready  (m_wready[0]),
        .m0_axi_bresp   (m0_bresp),
        .m0_axi_bvalid  (m_bvalid[0]),
        .m0_axi_bready  (m_bready[0]),
        .m1_axi_awaddr  (m_awaddr[1]),
        .m1_axi_awvalid (m_awvalid[1]),
        .m1_axi_awready (m_awready[1]),
        .m1_axi_wdata   (m_wdata[1]),
        .m1_axi_wvalid  (m_wvalid[1]),
        .m1_axi_wlast   (m_wlast[1]),
        .m1_axi_wready  (m_wready[1]),
        .m1_axi_bresp   (m1_bresp),
        .m1_axi_bvalid  (m_bvalid[1]),
        .m1_axi_bready  (m_bready[1]),
        .s_axi_awaddr   (s_awaddr),
        .s_axi_awvalid  (s_awvalid),
        .s_axi_awready  (s_awready),
        .s_axi_wdata    (s_wdata),
        .s_axi_wvalid   (s_wvalid),
        .s_axi_wlast    (s_wlast),
        .s_axi_wready   (s_wready),
        .s_axi_bresp    (s_bresp),
        .s_axi_bvalid   (s_bvalid),
        .s_axi_bready   (s_bready)
    );

    wire [37:0] all_out = {m_awready, m_wready, m_bvalid, m0_bresp, m1_bresp,
                           s_awaddr, s_awvalid, s_wdata, s_wvalid, s_wlast, s_bready};

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // scoreboard: {onehot master, fields} as the slave/requester should see them
    logic [17:0] exp_aw [$];
    logic [10:0] exp_w  [$];
    logic [5:0]  exp_b  [$];
    logic [1:0]  slv_resp [$];
    int          aw_log [$];
    int          b_log  [$];
    logic [1:0]  active = 2'b00;
    int          stall_at = 0;

    task automatic expect_txn(input int m, input logic [15:0] addr, input int n,
                              input logic [7:0] d0, input logic [1:0] resp);
        logic [1:0] oh;
        oh = (m == 1) ? 2'b10 : 2'b01;
        exp_aw.push_back({oh, addr});
        for (int i = 0; i < n; i++) begin
            exp_w.push_back({oh, (i == n - 1), d0 + 8'(i)});
        end
        exp_b.push_back({oh, (m == 0) ? resp : 2'b00, (m == 1) ? resp : 2'b00});
        slv_resp.push_back(resp);
    endtask

    // Monitor and slave responder. Handshakes are judged at the negedge;
    // slave inputs change 1 time unit after the posedge.
    initial begin
        int   beats = 0;
        int   stall_left = 0;
        logic aw_hs, w_hs, b_hs, w_last;
        s_awready = 1'b1;
        s_wready  = 1'b1;
        s_bvalid  = 1'b0;
        s_bresp   = 2'b00;
        forever begin
            @(negedge clk);
            aw_hs = 1'b0; w_hs = 1'b0; b_hs = 1'b0; w_last = 1'b0;
            if (axi_aresetn) begin
                aw_hs  = s_awvalid && s_awready;
                w_hs   = s_wvalid && s_wready;
                b_hs   = s_bvalid && s_bready;
                w_last = s_wlast;
                if (aw_hs) begin
                    aw_log.push_back(cyc);
                    if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
                    else chk("aw", {m_awready, s_awaddr}, exp_aw.pop_front());
                end
                if (w_hs) begin
                    if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
                    else chk("w", {m_wready, s_wlast, s_wdata}, exp_w.pop_front());
                end
                if (b_hs) begin
                    b_log.push_back(cyc);
                    if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
                    else chk("b", {m_bvalid, m0_bresp, m1_bresp}, exp_b.pop_front());
                end
                if (!active[0]) chk("idle_m0", {m_awready[0], m_wready[0], m_bvalid[0], m0_bresp}, 0);
                if (!active[1]) chk("idle_m1", {m_awready[1], m_wready[1], m_bvalid[1], m1_bresp}, 0);
            end
            @(posedge clk);
            #1;
            if (!axi_aresetn) begin
                beats = 0; stall_left = 0;
                s_bvalid = 1'b0; s_wready = 1'b1;
            end else begin
                if (b_hs) s_bvalid = 1'b0;
                if (w_hs) begin
                    beats++;
                    if (w_last) begin
                        beats = 0;
                        s_bvalid = 1'b1;
                        s_bresp = (slv_resp.size() != 0) ? slv_resp.pop_front() : 2'b11;
                    end else if (stall_at != 0 && beats == stall_at) begin
                        stall_left = 3;
                        stall_at = 0;
                    end
                end
                s_wready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
            end
        end
    end

    // which: 0 awready, 1 wready, 2 bvalid
    task automatic wait_neg(input int m, input int which, output bit ok);
        int   t;
        logic v;
        t = 0;
        ok = 1'b0;
        while (t < 500) begin
            @(negedge clk);
            t++;
            if (which == 0) begin
                v = m_awready[m];
                if (v) chk("w_stall_in_addr", m_wready[m], 0);
            end else if (which == 1) v = m_wready[m];
            else v = m_bvalid[m];
            if (v) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("timeout", 1, 0);
    endtask

    // Called at posedge+1; returns at posedge+1 right after the B handshake.
    // The first W beat is presented together with AW.
    task automatic drive(input int m, input logic [15:0] addr, input int n, input logic [7:0] d0);
        bit ok;
        active[m]    = 1'b1;
        m_awaddr[m]  = addr;
        m_awvalid[m] = 1'b1;
        m_wdata[m]   = d0;
        m_wvalid[m]  = 1'b1;
        m_wlast[m]   = (n == 1);
        wait_neg(m, 0, ok);
        @(posedge clk); #1;
        m_awvalid[m] = 1'b0;
        m_awaddr[m]  = '0;
        for (int i = 0; i < n; i++) begin
            m_wdata[m]  = d0 + 8'(i);
            m_wlast[m]  = (i == n - 1);
            m_wvalid[m] = 1'b1;
            wait_neg(m, 1, ok);
            @(posedge clk); #1;
        end
        m_wvalid[m] = 1'b0;
        m_wlast[m]  = 1'b0;
        m_wdata[m]  = '0;
        m_bready[m] = 1'b1;
        wait_neg(m, 2, ok);
        @(posedge clk); #1;
        m_bready[m] = 1'b0;
        active[m]   = 1'b0;
    endtask

    task automatic do_reset();
        axi_aresetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        axi_aresetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int start;
        axi_aresetn = 1'b0;
        m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
        for (int i = 0; i < 2; i++) begin
            m_awaddr[i] = '0;
            m_wdata[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_out, 0);
        axi_aresetn = 1'b1;
        @(posedge clk); #1;
        chk("idle_outputs", all_out, 0);

        // m0 alone, 4 beats
        expect_txn(0, 16'h0010, 4, 8'hA1, RESP_OKAY);
        drive(0, 16'h0010, 4, 8'hA1);

        // simultaneous request straight after reset
        do_reset();
        aw_log.delete(); b_log.delete();
        expect_txn(0, 16'h0100, 2, 8'h10, RESP_OKAY);
        expect_txn(1, 16'h0200, 3, 8'h20, RESP_OKAY);
        start = cyc;
        fork
            drive(0, 16'h0100, 2, 8'h10);
            drive(1, 16'h0200, 3, 8'h20);
        join
        if (aw_log.size() == 2 && b_log.size() == 2) begin
            chk("grant_latency", aw_log[0] - start, 1);
            chk("back_to_back_gap", aw_log[1] - b_log[0], 2);
        end else begin
            chk("log_count", aw_log.size() * 16 + b_log.size(), 34);
        end

        // continuous contention: m0, m1, m0, m1
        expect_txn(0, 16'h0300, 2, 8'h30, RESP_OKAY);
        expect_txn(1, 16'h0400, 2, 8'h40, RESP_OKAY);
        expect_txn(0, 16'h0310, 2, 8'h38, RESP_OKAY);
        expect_txn(1, 16'h0410, 2, 8'h48, RESP_OKAY);
        fork
            begin
                drive(0, 16'h0300, 2, 8'h30);
                drive(0, 16'h0310, 2, 8'h38);
            end
            begin
                drive(1, 16'h0400, 2, 8'h40);
                drive(1, 16'h0410, 2, 8'h48);
            end
        join

        // slave stalls wready for 3 cycles after beat 2 and answers SLVERR
        stall_at = 2;
        expect_txn(1, 16'h0500, 5, 8'h50, RESP_SLVERR);
        drive(1, 16'h0500, 5, 8'h50);

        // reset while beat 2 of 4 is on the bus
        exp_aw.push_back({2'b01, 16'h0040});
        exp_w.push_back({2'b01, 1'b0, 8'hC1});
        active[0] = 1'b1;
        m_awaddr[0] = 16'h0040; m_awvalid[0] = 1'b1;
        m_wdata[0] = 8'hC1; m_wvalid[0] = 1'b1; m_wlast[0] = 1'b0;
        wait_neg(0, 0, ok);
        @(posedge clk); #1;
        m_awvalid[0] = 1'b0; m_awaddr[0] = '0;
        wait_neg(0, 1, ok);
        @(posedge clk); #1;
        m_wdata[0] = 8'hC2;
        #2;
        chk("pre_reset_wvalid", s_wvalid, 1);
        axi_aresetn = 1'b0;
        #1;
        chk("mid_reset_outputs", all_out, 0);
        m_wvalid[0] = 1'b0; m_wdata[0] = '0;
        active[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        axi_aresetn = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", all_out, 0);
        expect_txn(0, 16'h0050, 2, 8'hD0, RESP_OKAY);
        drive(0, 16'h0050, 2, 8'hD0);

        // single-beat burst at the top address
        expect_txn(0, 16'hFFFF, 1, 8'h77, RESP_OKAY);
        drive(0, 16'hFFFF, 1, 8'h77);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_aw.size() + exp_w.size() + exp_b.size(), 0);
        chk("final_idle", all_out, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
